// File: rtl/softmax_pkg.sv
// Shared Q7.8 constants, FSM encoding and the saturating subtract used by softmax_max_sub.
package softmax_pkg;

    localparam int unsigned Q_DATA_W = 16;
    localparam logic [Q_DATA_W-1:0] SAT_MIN = 16'hF001;

    typedef enum logic [1:0] {
        S_FILL,
        S_PRIME,
        S_DRAIN
    } state_e;

    // Difference at Q_DATA_W+1 bits, clamped below at SAT_MIN (-15.996).
    function automatic logic [Q_DATA_W-1:0] sat_sub(input logic [Q_DATA_W-1:0] a,
                                                    input logic [Q_DATA_W-1:0] b);
        logic signed [Q_DATA_W:0] diff;
        logic signed [Q_DATA_W:0] lim;
        diff = $signed({a[Q_DATA_W-1], a}) - $signed({b[Q_DATA_W-1], b});
        lim  = $signed({SAT_MIN[Q_DATA_W-1], SAT_MIN});
        return (diff < lim) ? SAT_MIN : diff[Q_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/softmax_vec_buf.sv
// Simple dual-port vector buffer: one write port, registered read with 1-cycle latency.
module softmax_vec_buf #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/softmax_max_sub.sv
// Buffers one Q7.8 vector, tracks its max, then replays sat(x - max).
// Optional SOFTMAX_MAXSUB_STATS_EN adds registered oMaxVal/oLen outputs.
module softmax_max_sub
    import softmax_pkg::*;
#(
    parameter int unsigned DATA_W  = Q_DATA_W,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iLast,
    input  logic [DATA_W-1:0] iData,
    output logic              oValid,
    input  logic              iReady,
    output logic              oLast,
    output logic [DATA_W-1:0] oData,
    output logic              oTrunc
`ifdef SOFTMAX_MAXSUB_STATS_EN
    ,
    output logic [DATA_W-1:0] oMaxVal,
    output logic [ADDR_W:0]   oLen
`endif
);

    localparam logic [ADDR_W:0] CAP_IDX = (ADDR_W + 1)'(MAX_LEN - 1);

    state_e                   state_q, state_d;
    logic [ADDR_W:0]          count_q, count_d;
    logic [ADDR_W:0]          len_q, len_d;
    logic [ADDR_W:0]          idx_q, idx_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic                     trunc_q, trunc_d;

    logic                     in_fire, out_fire, at_last_out, at_cap;
    logic [ADDR_W:0]          idx_nxt;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;

    assign oReady      = (state_q == S_FILL) && !iRst;
    assign in_fire     = iValid && oReady;
    assign oValid      = (state_q == S_DRAIN);
    assign out_fire    = oValid && iReady;
    assign at_last_out = (idx_q == len_q - 1'b1);
    assign at_cap      = (count_q == CAP_IDX);
    assign oLast       = oValid && at_last_out;
    assign oData       = oValid ? sat_sub(rd_data, max_q) : '0;
    assign oTrunc      = trunc_q;
    assign idx_nxt     = idx_q + 1'b1;

    // Read-ahead: the next element is fetched on each handshake so drain has no bubbles.
    assign rd_en   = (state_q == S_PRIME) || (out_fire && !at_last_out);
    assign rd_addr = (state_q == S_PRIME) ? '0 : idx_nxt[ADDR_W-1:0];

    softmax_vec_buf #(
        .DATA_W (DATA_W),
        .MAX_LEN(MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i    (iClk),
        .wr_en_i  (in_fire),
        .wr_addr_i(count_q[ADDR_W-1:0]),
        .wr_data_i(iData),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        idx_d   = idx_q;
        max_d   = max_q;
        trunc_d = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (in_fire) begin
                    count_d = count_q + 1'b1;
                    if ((count_q == '0) || ($signed(iData) > max_q)) begin
                        max_d = $signed(iData);
                    end
                    if (iLast || at_cap) begin
                        len_d   = count_q + 1'b1;
                        count_d = '0;
                        state_d = S_PRIME;
                        trunc_d = at_cap && !iLast;
                    end
                end
            end
            S_PRIME: begin
                idx_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (at_last_out) begin
                        state_d = S_FILL;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_FILL;
            count_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef SOFTMAX_MAXSUB_STATS_EN
    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic [ADDR_W:0]   stat_len_q, stat_len_d;

    always_comb begin
        max_val_d  = max_val_q;
        stat_len_d = stat_len_q;
        if ((state_q == S_FILL) && (state_d == S_PRIME)) begin
            max_val_d  = max_d;
            stat_len_d = len_d;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            max_val_q  <= '0;
            stat_len_q <= '0;
        end else begin
            max_val_q  <= max_val_d;
            stat_len_q <= stat_len_d;
        end
    end

    assign oMaxVal = max_val_q;
    assign oLen    = stat_len_q;
`endif

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub with hand-computed expected outputs.
module tb_softmax_max_sub;

    logic        iClk;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic        iLast;
    logic [15:0] iData;
    logic        oValid;
    logic        iReady;
    logic        oLast;
    logic [15:0] oData;
    logic        oTrunc;
`ifdef SOFTMAX_MAXSUB_STATS_EN
    logic [15:0] oMaxVal;
    logic [6:0]  oLen;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [64];

    softmax_max_sub #(
        .DATA_W (16),
        .MAX_LEN(64),
        .ADDR_W (6)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iValid(iValid),
        .oReady(oReady),
        .iLast (iLast),
        .iData (iData),
        .oValid(oValid),
        .iReady(iReady),
        .oLast (oLast),
        .oData (oData),
        .oTrunc(oTrunc)
`ifdef SOFTMAX_MAXSUB_STATS_EN
        ,
        .oMaxVal(oMaxVal),
        .oLen   (oLen)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds iValid high; caller deasserts it when the vector is done.
    task automatic send(input logic [15:0] d, input logic l, input logic want_trunc);
        int guard;
        guard  = 0;
        iValid = 1'b1;
        iData  = d;
        iLast  = l;
        while (!oReady && guard < 200) begin
            tick();
            guard++;
        end
        if (!oReady) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: got oReady=0 expected 1");
        end
        tick();
        chk("o_trunc", {31'd0, oTrunc}, {31'd0, want_trunc});
    endtask

    task automatic drain(input int n_total, input int n_take, input bit bp);
        for (int k = 0; k < n_take; k++) begin
            int  guard;
            bit  done;
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                iReady = (bp && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
                chk("o_valid", {31'd0, oValid}, 32'd1);
                chk("o_ready_drain", {31'd0, oReady}, 32'd0);
                chk("o_data", {16'd0, oData}, {16'd0, exp_q[k]});
                chk("o_last", {31'd0, oLast}, (k == n_total - 1) ? 32'd1 : 32'd0);
                done = iReady;
                tick();
                guard++;
            end
        end
        iReady = 1'b0;
    endtask

    initial begin
        iRst   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iLast  = 1'b0;
        iData  = '0;
        #1 iRst = 1'b1;
        #2;
        chk("rst_o_ready", {31'd0, oReady}, 32'd0);
        chk("rst_o_valid", {31'd0, oValid}, 32'd0);
        chk("rst_o_last", {31'd0, oLast}, 32'd0);
        chk("rst_o_data", {16'd0, oData}, 32'd0);
        chk("rst_o_trunc", {31'd0, oTrunc}, 32'd0);
        tick();
        tick();
        iRst = 1'b0;
        #1;
        chk("post_rst_o_ready", {31'd0, oReady}, 32'd1);

        // Basic vector, max 0x0380.
        send(16'h0100, 1'b0, 1'b0);
        send(16'h0380, 1'b0, 1'b0);
        send(16'hFE00, 1'b0, 1'b0);
        send(16'h0380, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        chk("basic_prime_o_valid", {31'd0, oValid}, 32'd0);
        tick();
        exp_q[0] = 16'hFD80;
        exp_q[1] = 16'h0000;
        exp_q[2] = 16'hFA80;
        exp_q[3] = 16'h0000;
        drain(4, 4, 1'b0);
        chk("basic_end_o_valid", {31'd0, oValid}, 32'd0);
        chk("basic_end_o_ready", {31'd0, oReady}, 32'd1);

        // Saturation.
        send(16'h7F00, 1'b0, 1'b0);
        send(16'h8000, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        chk("sat_prime_o_valid", {31'd0, oValid}, 32'd0);
        tick();
        exp_q[0] = 16'h0000;
        exp_q[1] = 16'hF001;
        drain(2, 2, 1'b0);

        // Backpressure, max 0x0100.
        send(16'h0010, 1'b0, 1'b0);
        send(16'h0050, 1'b0, 1'b0);
        send(16'hFFF0, 1'b0, 1'b0);
        send(16'h0100, 1'b0, 1'b0);
        send(16'h0080, 1'b0, 1'b0);
        send(16'h8000, 1'b0, 1'b0);
        send(16'h0100, 1'b0, 1'b0);
        send(16'h0000, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        tick();
        exp_q[0] = 16'hFF10;
        exp_q[1] = 16'hFF50;
        exp_q[2] = 16'hFEF0;
        exp_q[3] = 16'h0000;
        exp_q[4] = 16'hFF80;
        exp_q[5] = 16'hF001;
        exp_q[6] = 16'h0000;
        exp_q[7] = 16'hFF00;
        drain(8, 8, 1'b1);
        chk("bp_end_o_valid", {31'd0, oValid}, 32'd0);

        // Single element.
        send(16'h8000, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        tick();
        exp_q[0] = 16'h0000;
        drain(1, 1, 1'b0);
        chk("single_o_ready", {31'd0, oReady}, 32'd1);

        // Truncation: 64 beats k*0x10, max 0x03F0; beat 65 waits.
        for (int k = 0; k < 64; k++) begin
            send(16'(k * 16), 1'b0, (k == 63) ? 1'b1 : 1'b0);
            exp_q[k] = 16'(k * 16 - 1008);
        end
        iData = 16'h0200;
        iLast = 1'b0;
        chk("trunc_prime_o_valid", {31'd0, oValid}, 32'd0);
        tick();
        chk("trunc_drain_o_trunc", {31'd0, oTrunc}, 32'd0);
        drain(64, 64, 1'b0);
        chk("trunc_end_o_ready", {31'd0, oReady}, 32'd1);
        tick();
        chk("trunc_beat65_o_trunc", {31'd0, oTrunc}, 32'd0);
        send(16'h0100, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        tick();
        exp_q[0] = 16'h0000;
        exp_q[1] = 16'hFF00;
        drain(2, 2, 1'b0);

        // Reset mid-drain.
        send(16'h0100, 1'b0, 1'b0);
        send(16'h0200, 1'b0, 1'b0);
        send(16'h0300, 1'b0, 1'b0);
        send(16'h0400, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        tick();
        exp_q[0] = 16'hFD00;
        exp_q[1] = 16'hFE00;
        exp_q[2] = 16'hFF00;
        exp_q[3] = 16'h0000;
        drain(4, 2, 1'b0);
        iRst = 1'b1;
        #1;
        chk("mid_rst_o_valid", {31'd0, oValid}, 32'd0);
        chk("mid_rst_o_ready", {31'd0, oReady}, 32'd0);
        chk("mid_rst_o_data", {16'd0, oData}, 32'd0);
        tick();
        iRst = 1'b0;
        #1;
        chk("mid_rst_release_o_ready", {31'd0, oReady}, 32'd1);
        send(16'h0200, 1'b1, 1'b0);
        iValid = 1'b0;
        iLast  = 1'b0;
        tick();
        exp_q[0] = 16'h0000;
        drain(1, 1, 1'b0);
        chk("final_o_valid", {31'd0, oValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
